adder_pipe: RTL and testbench

Parametrised, carry-pipelined adder/subtractor with valid/ready handshake on both sides. It is the next-generation replacement for the fixed 32-bit combinational adder. It splits a WIDTH-bit addition into STAGES equal segments, registers the carry between segments, and sustains one operation per cycle under output backpressure. It sits in the datapath wherever a wide add/sub must close timing at full clock rate.

---
 rtl/adder_pkg.sv | 15 +
 rtl/adder_pipe_seg.sv | 40 ++++
 rtl/adder_pipe.sv | 139 +++++++++++++
 tb/tb_adder_pipe.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared constants and configuration helpers for the carry-pipelined adder.
package adder_pkg;

  localparam logic ADD = 1'b0;
  localparam logic SUB = 1'b1;

  function automatic int chunk_of(input int width, input int stages);
    return width / stages;
  endfunction

  function automatic bit width_ok(input int width, input int stages);
    return (stages >= 1) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_pipe_seg.sv
// One CHUNK-bit slice of the pipelined adder: registered sum chunk, carry-out
// and valid bit, all frozen while the pipeline is stalled.
module adder_pipe_seg
  import adder_pkg::*;
#(
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             adv,
  input  logic             valid,
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s_r,
  output logic             co_r,
  output logic             valid_r
);

  logic [CHUNK:0] total_s;

  // Chunk sum including the carry handed up from the stage below.
  always_comb begin
    total_s = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};
  end

  // Stage register; bubbles still load but keep valid_r low.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_r     <= {CHUNK{1'b0}};
      co_r    <= 1'b0;
      valid_r <= 1'b0;
    end else if (adv) begin
      s_r     <= total_s[CHUNK-1:0];
      co_r    <= total_s[CHUNK];
      valid_r <= valid;
    end
  end

endmodule

// File: rtl/adder_pipe.sv
// Carry-pipelined WIDTH-bit adder/subtractor with valid/ready on both sides.
// Upper operand chunks are skewed in, lower result chunks de-skewed out.
module adder_pipe
  import adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = chunk_of(WIDTH, STAGES);

  if (!width_ok(WIDTH, STAGES)) begin : g_bad_cfg
    $error("adder_pipe: WIDTH must be a non-zero multiple of STAGES");
  end

  logic              adv_s;
  logic [WIDTH-1:0]  b_eff_s;
  logic              c0_s;
  logic [STAGES-1:0] carry_s;
  logic [STAGES-1:0] valid_s;
  logic [WIDTH-1:0]  sum_s;
  logic              top_a_msb_s;
  logic              top_b_msb_s;
  logic [1:0]        top_msb_r;

  // Stall control and operand conditioning for subtraction.
  always_comb begin
    adv_s   = !valid_s[STAGES-1] || out_ready;
    b_eff_s = (sub == SUB) ? ~in2 : in2;
    c0_s    = (sub == SUB) ? ~cin : cin;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CHUNK-1:0] a_s;
    logic [CHUNK-1:0] b_s;
    logic             ci_s;
    logic             vin_s;
    logic [CHUNK-1:0] s_s;

    if (k == 0) begin : g_head
      assign a_s   = in1[CHUNK-1:0];
      assign b_s   = b_eff_s[CHUNK-1:0];
      assign ci_s  = c0_s;
      assign vin_s = in_valid;
    end else begin : g_skew
      logic [CHUNK-1:0] a_sk_r [k];
      logic [CHUNK-1:0] b_sk_r [k];

      // Delay chunk k by k cycles so it meets the carry from the stage below.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < k; j++) begin
            a_sk_r[j] <= {CHUNK{1'b0}};
            b_sk_r[j] <= {CHUNK{1'b0}};
          end
        end else if (adv_s) begin
          a_sk_r[0] <= in1[k*CHUNK +: CHUNK];
          b_sk_r[0] <= b_eff_s[k*CHUNK +: CHUNK];
          for (int j = 1; j < k; j++) begin
            a_sk_r[j] <= a_sk_r[j-1];
            b_sk_r[j] <= b_sk_r[j-1];
          end
        end
      end

      assign a_s   = a_sk_r[k-1];
      assign b_s   = b_sk_r[k-1];
      assign ci_s  = carry_s[k-1];
      assign vin_s = valid_s[k-1];
    end

    adder_pipe_seg #(.CHUNK(CHUNK)) u_seg (
      .clk     (clk),
      .rst     (rst),
      .adv     (adv_s),
      .valid   (vin_s),
      .a       (a_s),
      .b       (b_s),
      .ci      (ci_s),
      .s_r     (s_s),
      .co_r    (carry_s[k]),
      .valid_r (valid_s[k])
    );

    if (k == STAGES-1) begin : g_tail
      assign sum_s[k*CHUNK +: CHUNK] = s_s;
      assign top_a_msb_s             = a_s[CHUNK-1];
      assign top_b_msb_s             = b_s[CHUNK-1];
    end else begin : g_deskew
      logic [CHUNK-1:0] s_dsk_r [STAGES-1-k];

      // Hold finished low chunks until the top chunk catches up.
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int j = 0; j < STAGES-1-k; j++) begin
            s_dsk_r[j] <= {CHUNK{1'b0}};
          end
        end else if (adv_s) begin
          s_dsk_r[0] <= s_s;
          for (int j = 1; j < STAGES-1-k; j++) begin
            s_dsk_r[j] <= s_dsk_r[j-1];
          end
        end
      end

      assign sum_s[k*CHUNK +: CHUNK] = s_dsk_r[STAGES-2-k];
    end
  end

  // Operand sign bits travel alongside the top stage for the overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      top_msb_r <= 2'b00;
    end else if (adv_s) begin
      top_msb_r <= {top_a_msb_s, top_b_msb_s};
    end
  end

  assign in_ready  = adv_s;
  assign out_valid = valid_s[STAGES-1];
  assign sum       = sum_s;
  assign cout      = carry_s[STAGES-1];
  assign ovf       = (top_msb_r[1] == top_msb_r[0]) && (sum_s[WIDTH-1] != top_msb_r[1]);

endmodule

// File: tb/tb_adder_pipe.sv
// Directed bench for adder_pipe: 32-bit/4-stage vector table, streaming with
// backpressure, mid-flight reset, and an 8-bit/1-stage instance.
module tb_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [31:0] in1, in2, sum;
  logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0]  in1_8, in2_8, sum8;

  int n_tests = 0;
  int n_fail  = 0;

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in1(in1), .in2(in2), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  adder_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .in1(in1_8), .in2(in2_8), .cin(cin8), .sub(sub8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .cout(cout8), .ovf(ovf8)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        c;
    logic        s;
    logic [31:0] exp_sum;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  localparam int N_VEC = 8;
  vec_t vecs [N_VEC];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference: {ovf, cout, sum} straight from the arithmetic definition.
  function automatic logic [33:0] model(input logic [31:0] x, input logic [31:0] y,
                                        input logic c, input logic s);
    logic [31:0] be;
    logic        c0;
    logic [32:0] t;
    logic        ov;
    be = s ? ~y : y;
    c0 = s ? ~c : c;
    t  = {1'b0, x} + {1'b0, be} + {32'd0, c0};
    ov = (x[31] == be[31]) && (t[31] != x[31]);
    return {ov, t};
  endfunction

  logic [31:0] st_a [10];
  logic [31:0] st_b [10];
  logic        st_c [10];
  logic        st_s [10];
  logic [33:0] exp_r;
  logic [33:0] held;
  logic        prev_stall;
  int          lat, sent, got, stalls, extra;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[2] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1};
    vecs[4] = '{32'hFF32_0012, 32'hBD30_2991, 1'b1, 1'b0, 32'hBC62_29A4, 1'b1, 1'b0};
    vecs[5] = '{32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0006, 1'b1, 1'b0};
    vecs[6] = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0};
    vecs[7] = '{32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; in1 = 32'd0; in2 = 32'd0;
    cin = 1'b0; sub = 1'b0;
    in_valid8 = 1'b0; out_ready8 = 1'b1; in1_8 = 8'd0; in2_8 = 8'd0;
    cin8 = 1'b0; sub8 = 1'b0;
    tick; tick;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid8", out_valid8, 0);

    // Single operations through an empty pipeline, measuring latency.
    for (int i = 0; i < N_VEC; i++) begin
      in1 = vecs[i].a; in2 = vecs[i].b; cin = vecs[i].c; sub = vecs[i].s;
      in_valid = 1'b1;
      tick;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 20) begin
        tick;
        lat++;
      end
      check($sformatf("vec%0d_latency", i), lat, 4);
      check($sformatf("vec%0d_sum", i), sum, vecs[i].exp_sum);
      check($sformatf("vec%0d_cout", i), cout, vecs[i].exp_cout);
      check($sformatf("vec%0d_ovf", i), ovf, vecs[i].exp_ovf);
      tick;
    end

    // Back-to-back stream with a three-cycle output stall.
    for (int i = 0; i < 10; i++) begin
      st_a[i] = $urandom;
      st_b[i] = $urandom;
      st_c[i] = 1'($urandom_range(0, 1));
      st_s[i] = 1'($urandom_range(0, 1));
    end
    sent = 0; got = 0; stalls = 0; prev_stall = 1'b0; held = 34'd0;
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 7);
      if (sent < 10) begin
        in1 = st_a[sent]; in2 = st_b[sent]; cin = st_c[sent]; sub = st_s[sent];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (prev_stall) begin
        check($sformatf("stall_hold_c%0d", cyc), {ovf, cout, sum}, held);
      end
      if (out_valid && !out_ready) begin
        stalls++;
        check($sformatf("stall_in_ready_c%0d", cyc), in_ready, 0);
      end
      if (out_valid && out_ready) begin
        exp_r = model(st_a[got], st_b[got], st_c[got], st_s[got]);
        check($sformatf("stream%0d_result", got), {ovf, cout, sum}, exp_r);
        got++;
      end
      if (in_valid && in_ready) sent++;
      held       = {ovf, cout, sum};
      prev_stall = out_valid && !out_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    check("stream_count", got, 10);
    check("stream_stall_cycles", stalls, 3);
    extra = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) extra++;
      tick;
    end
    check("stream_no_duplicates", extra, 0);

    // Reset with three operations in flight.
    for (int i = 0; i < 3; i++) begin
      in1 = 32'h1111_1111 * (i + 1); in2 = 32'h2222_2222; cin = 1'b1; sub = 1'b0;
      in_valid = 1'b1;
      tick;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_sum", sum, 0);
    check("midrst_cout", cout, 0);
    check("midrst_ovf", ovf, 0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (out_valid) extra++;
    end
    check("midrst_no_stale", extra, 0);

    // Single-stage 8-bit configuration.
    check("w8_in_ready", in_ready8, 1);
    in1_8 = 8'hFF; in2_8 = 8'hFF; cin8 = 1'b1; sub8 = 1'b0; in_valid8 = 1'b1;
    tick;
    in_valid8 = 1'b0;
    check("w8_latency1_valid", out_valid8, 1);
    check("w8_sum", sum8, 8'hFF);
    check("w8_cout", cout8, 1);
    check("w8_ovf", ovf8, 0);
    tick;
    check("w8_drained", out_valid8, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
